// File: rtl/exception_unit_if.sv
// rtl/exception_unit_if.sv - pipeline/CP0 side bundle of the precise-exception controller
interface exception_unit_if;
   logic        mem_valid_i;
   logic        stall_i;
   logic [31:0] pc_i;
   logic        delayslot_i;
   logic        adel_if_i;
   logic        ri_i;
   logic        ov_i;
   logic        syscall_i;
   logic        break_i;
   logic        adel_i;
   logic        ades_i;
   logic        eret_i;
   logic [31:0] badaddr_i;
   logic [5:0]  hw_int_i;
   logic [31:0] status_i;
   logic [31:0] cause_i;
   logic [31:0] epc_i;

   logic [5:0]  ip_hw_o;
   logic        exc_o;
   logic        eret_o;
   logic [4:0]  exccode_o;
   logic        exc_delayslot_o;
   logic [31:0] exc_pc_o;
   logic [31:0] badvaddr_o;
   logic        flush_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        busy_o;

   modport master (
      output mem_valid_i, stall_i, pc_i, delayslot_i,
      output adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i,
      output badaddr_i, hw_int_i, status_i, cause_i, epc_i,
      input  ip_hw_o, exc_o, eret_o, exccode_o, exc_delayslot_o, exc_pc_o,
      input  badvaddr_o, flush_o, redirect_o, redirect_pc_o, busy_o
   );

   modport slave (
      input  mem_valid_i, stall_i, pc_i, delayslot_i,
      input  adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i,
      input  badaddr_i, hw_int_i, status_i, cause_i, epc_i,
      output ip_hw_o, exc_o, eret_o, exccode_o, exc_delayslot_o, exc_pc_o,
      output badvaddr_o, flush_o, redirect_o, redirect_pc_o, busy_o
   );
endinterface

// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - precise-exception controller at the MEM/WB boundary
module exception_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic             clk,
   input  logic             rst,
   exception_unit_if.slave  exc_if
);

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [5:0]  r_int_s1;
   logic [5:0]  r_int_s2;

   logic [4:0]  r_code;
   logic [31:0] r_pc;
   logic        r_delayslot;
   logic [31:0] r_badvaddr;
   logic        r_kind_exc;

   logic        w_int_req;
   logic        w_exc_pending;
   logic [4:0]  w_code;
   logic [31:0] w_badvaddr;
   logic        w_accept;
   logic        w_commit;

   logic        w_unused_ok;
   assign w_unused_ok = &{1'b0, exc_if.status_i[31:16], exc_if.status_i[7:2],
                          exc_if.cause_i[31:10], exc_if.cause_i[7:0]};

   // Hardware interrupt lines are asynchronous; two flops before any use.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_int_s1 <= 6'd0;
         r_int_s2 <= 6'd0;
      end else begin
         r_int_s1 <= exc_if.hw_int_i;
         r_int_s2 <= r_int_s1;
      end
   end

   assign exc_if.ip_hw_o = r_int_s2;

   assign w_int_req = exc_if.status_i[0] & ~exc_if.status_i[1] &
                      (|({r_int_s2, exc_if.cause_i[9:8]} & exc_if.status_i[15:8]));

   always_comb begin
      w_code        = EXC_INT;
      w_badvaddr    = 32'd0;
      w_exc_pending = 1'b1;
      if (w_int_req) begin
         w_code = EXC_INT;
      end else if (exc_if.adel_if_i) begin
         w_code     = EXC_ADEL;
         w_badvaddr = exc_if.pc_i;
      end else if (exc_if.ri_i) begin
         w_code = EXC_RI;
      end else if (exc_if.ov_i) begin
         w_code = EXC_OV;
      end else if (exc_if.syscall_i) begin
         w_code = EXC_SYS;
      end else if (exc_if.break_i) begin
         w_code = EXC_BP;
      end else if (exc_if.adel_i) begin
         w_code     = EXC_ADEL;
         w_badvaddr = exc_if.badaddr_i;
      end else if (exc_if.ades_i) begin
         w_code     = EXC_ADES;
         w_badvaddr = exc_if.badaddr_i;
      end else begin
         w_exc_pending = 1'b0;
      end
   end

   assign w_accept = (r_state == ST_IDLE) & exc_if.mem_valid_i & ~exc_if.stall_i &
                     (w_exc_pending | exc_if.eret_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next_state = ST_COMMIT;
         ST_COMMIT: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // ERET records code/badvaddr as zero; only the kind bit distinguishes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_code      <= 5'd0;
         r_pc        <= 32'd0;
         r_delayslot <= 1'b0;
         r_badvaddr  <= 32'd0;
         r_kind_exc  <= 1'b0;
      end else if (w_accept) begin
         r_code      <= w_exc_pending ? w_code : 5'd0;
         r_pc        <= exc_if.pc_i;
         r_delayslot <= exc_if.delayslot_i;
         r_badvaddr  <= w_exc_pending ? w_badvaddr : 32'd0;
         r_kind_exc  <= w_exc_pending;
      end
   end

   assign w_commit = (r_state == ST_COMMIT);

   assign exc_if.exc_o           = w_commit & r_kind_exc;
   assign exc_if.eret_o          = w_commit & ~r_kind_exc;
   assign exc_if.flush_o         = w_commit;
   assign exc_if.redirect_o      = w_commit;
   assign exc_if.busy_o          = w_commit;
   assign exc_if.exccode_o       = r_code;
   assign exc_if.exc_pc_o        = r_pc;
   assign exc_if.exc_delayslot_o = r_delayslot;
   assign exc_if.badvaddr_o      = r_badvaddr;

   // EPC is read live in COMMIT so an MTC0 EPC just ahead of ERET is honoured.
   assign exc_if.redirect_pc_o = !w_commit ? 32'd0 :
                                 (r_kind_exc ? EXC_VECTOR : exc_if.epc_i);

endmodule

// File: doc/exception_unit.md
# exception_unit

Precise-exception controller for the five-stage MIPS core, sitting at the MEM/WB boundary. Collects exception and ERET requests from the instruction in MEM, synchronizes external hardware interrupts, and prioritizes them against the CP0 Status/Cause state. Drives the CP0 register file's event inputs (flags, code, PC, delay-slot, bad address). Flushes the pipeline and redirects fetch to the exception vector or to EPC.

## Interface
- EXC_VECTOR, 32'hBFC00380, exception entry address
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_valid_i  in  1  MEM holds a real (non-bubble) instruction
- stall_i  in  1  pipeline stalled; no event accepted while high
- pc_i  in  32  PC of MEM instruction
- delayslot_i  in  1  MEM instruction is in a branch delay slot
- adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_i, ades_i, eret_i  in  1 each  per-instruction event flags
- badaddr_i  in  32  data address of MEM load/store
- hw_int_i  in  6  asynchronous external interrupt lines
- status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC
- ip_hw_o  out  6  synchronized interrupt lines, to Cause[15:10]
- exc_o  out  1  take-exception pulse to CP0
- eret_o  out  1  ERET pulse to CP0
- exccode_o  out  5  ExcCode for Cause[6:2]
- exc_delayslot_o  out  1  to Cause.BD
- exc_pc_o  out  32  faulting PC; CP0 subtracts 4 when BD=1
- badvaddr_o  out  32  BadVAddr value, valid with exc_o
- flush_o  out  1  kill IF..MEM
- redirect_o  out  1  load redirect_pc_o into fetch PC
- redirect_pc_o  out  32  new fetch address
- busy_o  out  1  unit is in COMMIT

## Operation
- Interrupt sync: two-flop synchronizer per line; ip_hw_o = second stage.
- int_req = status_i[0] & ~status_i[1] & |({ip_hw_o, cause_i[9:8]} & status_i[15:8]).
- Accept condition in IDLE: mem_valid_i & ~stall_i & (int_req | any flag).
- Priority: Int(0) > AdEL fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL data(4) > AdES(5) > ERET. ERET is chosen only when no exception is pending.
- badvaddr: pc_i for fetch AdEL; badaddr_i for data AdEL/AdES; 0 otherwise.
- Accept latches code, pc_i, delayslot_i, badvaddr, and kind (exc/eret). Transition IDLE→COMMIT.
- COMMIT lasts one cycle, then returns to IDLE unconditionally:
  - exc_o or eret_o = 1
  - flush_o = 1
  - redirect_o = 1
  - busy_o = 1
  - redirect_pc_o = EXC_VECTOR for exc, epc_i sampled in COMMIT for ERET. Sampling in COMMIT sees any earlier MTC0 EPC write.
- Requests arriving during COMMIT are ignored; that instruction is flushed.
- stall_i high in IDLE: nothing latched; the request is re-evaluated each cycle until stall_i drops.
- Interrupt with mem_valid_i=0: not taken until a valid instruction reaches MEM.
- Outputs exccode_o, exc_pc_o, exc_delayslot_o, badvaddr_o hold their latched values outside COMMIT. Consumers qualify them with exc_o.

## Timing
- Reset: state IDLE; synchronizer flops 0; every output 0, except redirect_pc_o = 0.
- Interrupt latency, line to ip_hw_o: 2 cycles.
- Request accepted at edge T (IDLE, conditions true). COMMIT outputs are high during cycle T+1 and sampled by CP0/fetch at edge T+2.
- Pulses last exactly one cycle; there is never back-to-back COMMIT.
- rst during COMMIT: next cycle IDLE, all pulses 0, latched event discarded.
- Outputs are registered; no combinational path from inputs to exc_o, eret_o or flush_o.

## Test plan
- Reset: assert rst 2 cycles with hw_int_i=6'h3F → all outputs 0, busy_o=0; ip_hw_o=6'h3F two cycles after rst drops.
- Syscall, not in delay slot: pc_i=0xBFC00100, syscall_i=1 → next cycle exc_o=1, exccode_o=8, exc_pc_o=0xBFC00100, exc_delayslot_o=0, redirect_pc_o=0xBFC00380, flush_o=1; cycle after that, all pulses 0.
- Priority with delay slot: ri_i=1, ov_i=1, break_i=1, delayslot_i=1 → exccode_o=10, exc_delayslot_o=1, single COMMIT.
- Data AdES: badaddr_i=0x80000003, ades_i=1 → exccode_o=5, badvaddr_o=0x80000003.
- Interrupt masking: status_i=0x0000FF01, hw_int_i[0]=1, mem_valid_i=1 → after sync, exccode_o=0. Repeat with status_i[1]=1 → no exc_o. With status_i[10]=0 → no exc_o.
- ERET and stall:
  - eret_i=1, epc_i=0xBFC00200 → eret_o=1, exc_o=0, redirect_pc_o=0xBFC00200.
  - Same with stall_i=1 for 3 cycles → nothing happens until the cycle after stall_i drops.
